crc_rx_checker: RTL and testbench

- Receive-side counterpart of the configurable LFSR CRC generator.
- Accepts a serial stream: a message of programmable length, then its appended CRC field. Recomputes the CRC over the message bits with the same taps, bit width and init semantics, then compares it against the received field.
- Reports a one-cycle done pulse and a registered pass/fail flag.
- Sits between the serial bit source and the status/readout logic.

---
 rtl/crc_rx_checker.sv | 119 +++++++++++
 tb/tb_crc_rx_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/crc_rx_checker.sv
// Serial CRC receive checker: recomputes an LFSR CRC over a programmable-length
// message, shifts in the appended CRC field and flags whether the two agree.
module crc_rx_checker #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       bitwidth,
  input  logic [WIDTH-1:0] taps,
  input  logic [WIDTH-1:0] init_value,
  input  logic [15:0]      msg_len,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic [WIDTH-1:0] crc_calc,
  output logic [WIDTH-1:0] crc_rx
);

  typedef enum logic [1:0] {IDLE, MSG, FCS, DONE} state_t;

  state_t           state;
  logic [5:0]       bw_q;
  logic [WIDTH-1:0] taps_q;
  logic [WIDTH-1:0] mask_q;
  logic [15:0]      cnt;

  logic [WIDTH-1:0] mask_next;
  logic [6:0]       n_next;
  logic [6:0]       n_bits;
  logic             fb;
  logic             accept;
  logic [WIDTH-1:0] crc_step;
  logic [WIDTH-1:0] rx_step;

  always_comb begin
    // NOTE: shifting in two steps keeps n=64 well defined; a single shift by
    // bitwidth+1 would reach WIDTH and rely on out-of-range shift behaviour.
    mask_next = ~(({WIDTH{1'b1}} << bitwidth) << 1);
    n_next    = {1'b0, bitwidth} + 7'd1;
    n_bits    = {1'b0, bw_q} + 7'd1;
    accept    = in_valid & busy;
    fb        = crc_calc[bw_q] ^ in_bit;
    crc_step  = ((crc_calc << 1) ^ (fb ? taps_q : '0)) & mask_q;
    rx_step   = ((crc_rx << 1) | {{(WIDTH-1){1'b0}}, in_bit}) & mask_q;
  end

  assign in_ready = busy;

  // NOTE: every register here is updated with <= so all state moves together
  // on the clock edge; blocking assignments would leak mid-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bw_q     <= '0;
      taps_q   <= '0;
      mask_q   <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      crc_calc <= '0;
      crc_rx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bw_q     <= bitwidth;
            taps_q   <= taps & mask_next;
            mask_q   <= mask_next;
            crc_calc <= init_value & mask_next;
            crc_rx   <= '0;
            crc_ok   <= 1'b0;
            busy     <= 1'b1;
            if (msg_len == 16'd0) begin
              state <= FCS;
              cnt   <= {9'd0, n_next};
            end else begin
              state <= MSG;
              cnt   <= msg_len;
            end
          end
        end
        MSG: begin
          if (accept) begin
            crc_calc <= crc_step;
            if (cnt == 16'd1) begin
              state <= FCS;
              cnt   <= {9'd0, n_bits};
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
        end
        FCS: begin
          if (accept) begin
            crc_rx <= rx_step;
            if (cnt == 16'd1) begin
              // Compare against the final field value so crc_ok lands with done.
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              crc_ok <= (crc_calc == rx_step);
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_rx_checker.sv
// Self-checking bench for crc_rx_checker: known CRC vectors, stalls, ignored
// starts, reset mid-frame; results are checked through a scoreboard queue.
module tb_crc_rx_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  bitwidth;
  logic [63:0] taps;
  logic [63:0] init_value;
  logic [15:0] msg_len;
  logic        in_valid;
  logic        in_bit;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic [63:0] crc_calc;
  logic [63:0] crc_rx;

  crc_rx_checker #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .bitwidth(bitwidth), .taps(taps),
    .init_value(init_value), .msg_len(msg_len), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .busy(busy), .done(done), .crc_ok(crc_ok),
    .crc_calc(crc_calc), .crc_rx(crc_rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] calc;
    logic [63:0] rx;
    logic        ok;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  byte unsigned msg_buf [0:15];
  bit          gaps;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_calc"}, crc_calc, e.calc);
        check({e.tag, "_rx"}, crc_rx, e.rx);
        check({e.tag, "_ok"}, {63'd0, crc_ok}, {63'd0, e.ok});
      end
    end
  end

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) msg_buf[i] = s[i];
  endtask

  // Called at a negedge; returns at the negedge after the bit was accepted.
  task automatic send_bit(input logic b);
    int guard = 0;
    if (gaps) begin
      int idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        in_valid = 1'b0;
        in_bit   = $urandom_range(0, 1);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_bit   = b;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // poke: 1 = stray start during MSG, 2 = stray start during the DONE cycle.
  task automatic run_frame(input string tag, input logic [5:0] bw, input logic [63:0] tp,
                           input logic [63:0] iv, input logic [15:0] len,
                           input logic [63:0] fcs, input logic [63:0] exp_calc,
                           input logic exp_ok, input int poke);
    exp_t e;
    int   n;
    n = int'(bw) + 1;
    e.tag = tag; e.calc = exp_calc; e.rx = fcs; e.ok = exp_ok;
    sb.push_back(e);
    bitwidth = bw; taps = tp; init_value = iv; msg_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bitwidth = 6'd3; taps = '1; init_value = '1; msg_len = 16'd1;
    for (int i = 0; i < int'(len); i++) begin
      if (poke == 1 && i == 3) start = 1'b1;
      send_bit(msg_buf[i/8][7 - (i % 8)]);
      start = 1'b0;
    end
    for (int j = 0; j < n; j++) send_bit(fcs[n-1-j]);
    check({tag, "_done_latency"}, {63'd0, done}, 64'd1);
    if (poke == 2) begin
      start = 1'b1; msg_len = 16'd4;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_idle_after"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bitwidth = '0; taps = '0; init_value = '0;
    msg_len = '0; in_valid = 1'b0; in_bit = 1'b0; gaps = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ok", {63'd0, crc_ok}, 64'd0);
    check("rst_calc", crc_calc, 64'd0);
    check("rst_rx", crc_rx, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    msg_buf[0] = 8'h01;
    run_frame("crc8_01", 6'd7, 64'h07, 64'h0, 16'd8, 64'h07, 64'h07, 1'b1, 0);

    load_str("123456789");
    run_frame("crc8_check", 6'd7, 64'h07, 64'h0, 16'd72, 64'hF4, 64'hF4, 1'b1, 0);
    run_frame("crc8_bad", 6'd7, 64'h07, 64'h0, 16'd72, 64'hF5, 64'hF4, 1'b0, 0);

    gaps = 1'b1;
    run_frame("ccitt_gaps", 6'd15, 64'h1021, 64'hFFFF, 16'd72, 64'h29B1, 64'h29B1, 1'b1, 0);
    gaps = 1'b0;

    run_frame("len0_masked", 6'd7, 64'hFFFF_FFFF_FFFF_FF07, 64'hFFFF_FFFF_FFFF_FFA5,
              16'd0, 64'hA5, 64'hA5, 1'b1, 0);
    run_frame("len0_n64", 6'd63, 64'h42F0_E1EB_A9EA_3693, 64'hDEAD_BEEF_0123_4567,
              16'd0, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1, 0);
    run_frame("n64_bad", 6'd63, 64'h1B, 64'hFFFF_0000_FFFF_0000,
              16'd0, 64'hFFFF_0000_FFFF_0001, 64'hFFFF_0000_FFFF_0000, 1'b0, 0);

    run_frame("start_in_msg", 6'd7, 64'h07, 64'h0, 16'd72, 64'hF4, 64'hF4, 1'b1, 1);
    msg_buf[0] = 8'h01;
    run_frame("start_in_done", 6'd7, 64'h07, 64'h0, 16'd8, 64'h07, 64'h07, 1'b1, 2);
    run_frame("after_done", 6'd7, 64'h07, 64'h0, 16'd8, 64'h07, 64'h07, 1'b1, 0);

    // Reset five bits into a frame: the partial frame must vanish.
    load_str("123456789");
    bitwidth = 6'd7; taps = 64'h07; init_value = 64'hFF; msg_len = 16'd72; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(msg_buf[0][7-i]);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_ready", {63'd0, in_ready}, 64'd0);
    check("midrst_calc", crc_calc, 64'd0);
    check("midrst_ok", {63'd0, crc_ok}, 64'd0);
    check("midrst_rx", crc_rx, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_frame("post_rst", 6'd15, 64'h1021, 64'hFFFF, 16'd72, 64'h29B1, 64'h29B1, 1'b1, 0);

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
